// File: rtl/code_stepper.sv
// Prescaled up/down 3-bit code stepper with run/stop FSM, load and
// a debounced-by-edge manual step input.
module code_stepper #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       dir,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       step,
  output logic [2:0] d,
  output logic       tick,
  output logic       wrap,
  output logic       running
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic {STOP, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    d_q, d_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          s1_q, s2_q, s3_q;
  logic          pulse;
  logic          adv;
  logic          auto_step;
  logic [2:0]    d_next;

  assign pulse  = s2_q & ~s3_q;
  assign d_next = dir ? d_q - 3'd1 : d_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    adv       = 1'b0;
    auto_step = 1'b0;
    unique case (state_q)
      STOP: begin
        cnt_d = '0;
        if (run) state_d = RUN;
        adv = pulse;
      end
      RUN: begin
        if (!run) begin
          state_d = STOP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          auto_step = 1'b1;
          adv       = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = STOP;
    endcase
    // Load wins over any step but leaves the run/stop state alone
    if (load) begin
      d_d   = load_val;
      cnt_d = '0;
    end else if (adv) begin
      d_d    = d_next;
      tick_d = auto_step;
      wrap_d = dir ? (d_q == 3'd0) : (d_q == 3'd7);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STOP;
      cnt_q   <= '0;
      d_q     <= 3'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      s1_q    <= step;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  assign d       = d_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign running = (state_q == RUN);

endmodule

// File: doc/code_stepper.md
CODE_STEPPER -- requirements
Module: code_stepper

Interface
REQ-001 Parameter DIV, default 4, prescaler period in Clock cycles per automatic step; legal range 2..2^26.
REQ-002 Clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset; one clock, no other clock domains.
REQ-004 Run  input  1  level; 1 = automatic stepping, 0 = stopped; synchronous to Clock.
REQ-005 Dir  input  1  step direction; 0 = increment, 1 = decrement; sampled when a step occurs.
REQ-006 Load  input  1  level; when high at an edge, D takes LoadVal.
REQ-007 LoadVal  input  3  value loaded into D.
REQ-008 Step  input  1  asynchronous pushbutton, active-high; manual single step while stopped.
REQ-009 D  output  3  registered code presented to the downstream 3-bit display register.
REQ-010 Tick  output  1  registered one-cycle pulse, asserted on the edge where an automatic step updates D.
REQ-011 Wrap  output  1  registered one-cycle pulse, asserted on the edge where D goes 7->0 (up) or 0->7 (down).
REQ-012 Running  output  1  1 when FSM is in RUN.

Function
REQ-013 FSM states: STOP, RUN; STOP->RUN on an edge with Run=1; RUN->STOP on an edge with Run=0.
REQ-014 Prescaler cnt: width ceil(log2(DIV)); in RUN counts 0..DIV-1, wraps to 0; forced to 0 in STOP and on the transition into STOP.
REQ-015 Automatic step: in RUN, on the edge where cnt==DIV-1, D <= D+1 mod 8 (Dir=0) or D-1 mod 8 (Dir=1), Tick=1 for that cycle.
REQ-016 First automatic step occurs DIV edges after the edge entering RUN; steps repeat every DIV edges thereafter.
REQ-017 Step synchroniser: three flops s1,s2,s3; step pulse = s2 & ~s3; Step rising before edge k updates D on edge k+2.
REQ-018 Manual step: in STOP, a step pulse advances D by one in direction Dir; Tick stays 0; Wrap rules apply.
REQ-019 In RUN, step pulses are discarded; holding Step high yields exactly one pulse per press.
REQ-020 Load priority: Load=1 overrides automatic and manual steps on that edge: D <= LoadVal, cnt <= 0, Tick=0, Wrap=0; FSM state unaffected.
REQ-021 Load held high for N edges keeps D=LoadVal and cnt=0 for all N edges; stepping resumes with a full DIV period after Load drops.
REQ-022 Wrap asserted only coincident with a step (automatic or manual) crossing the 7/0 boundary; never on Load.
REQ-023 Dir change mid-period takes effect at the next step; cnt not disturbed.
REQ-024 Run dropping on the same edge as cnt==DIV-1: no step, FSM enters STOP, cnt=0.
REQ-025 Tick and Wrap are never high for more than one consecutive cycle unless DIV... (DIV>=2 guarantees at least one low cycle between Ticks).

Reset
REQ-026 Reset=1 forces immediately, without a clock: D=3'b000, FSM=STOP, cnt=0, Tick=0, Wrap=0, Running=0, s1=s2=s3=0.
REQ-027 Reset asserted mid-period discards partial count and any in-flight step pulse; after release, block behaves as from power-up.
REQ-028 After Reset release with Run=1, FSM enters RUN on the first edge; first step DIV edges later.

Verification
REQ-029 DIV=4, Reset then Run=1, Dir=0, 10 edges -> D: 0,0,0,0,1,1,1,1,2,2 (edge1 enters RUN, steps at edges 4 and 8 counting from entry); Tick high on those edges only.
REQ-030 DIV=4, Run=1, D=7, Dir=0 -> next step D=0 with Wrap=1 and Tick=1 same cycle; Dir=1 from D=0 -> D=7, Wrap=1.
REQ-031 Run=0, D=2, Dir=1, Step held high 20 edges -> D=1 exactly once, on 3rd edge after Step rises; Tick=0 throughout.
REQ-032 Run=1, Load=1 with LoadVal=5 on the edge cnt==DIV-1 -> D=5, Tick=0, Wrap=0; next step DIV edges after Load falls gives D=6.
REQ-033 Run=1, cnt=2 of DIV=4, assert Reset between edges -> D=0, Running=0, Tick=0 immediately; release with Run=0 and Step low -> D stays 0 for 10 edges.
REQ-034 Run=1 dropped on edge with cnt==DIV-1 -> D unchanged, Running=0, Tick=0; re-raise Run -> first step DIV edges after re-entry.
